memory_control: RTL and testbench

Memory-side responder for the cache pair's `caches_if`: accepts instruction-fetch and data read/write requests from icache/dcache, arbitrates them onto a single-ported RAM, and returns `iwait`/`dwait` handshakes plus load data. Sits between `caches` and the RAM model or top-level system. Data requests have priority, and a streak counter guarantees instruction fetches are never starved.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/caches_if.sv | 36 +++
 rtl/memory_control.sv | 129 ++++++++++++
 tb/tb_memory_control.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the cache/memory side of the CPU:
//   word_t          - 32-bit machine word (addresses and data)
//   ramstate_t      - status reported by the RAM each cycle
//   memctl_state_t  - arbitration states of memory_control
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } memctl_state_t;

endpackage

// File: rtl/caches_if.sv
// ---------------------------------------------------------------------------
// caches_if
// Request/response bundle between the icache/dcache pair and memory_control.
//   iREN, iaddr           - instruction fetch request (cache -> memory)
//   iwait, iload          - instruction handshake and data (memory -> cache)
//   dREN, dWEN, daddr,
//   dstore                - data read/write request (cache -> memory)
//   dwait, dload          - data handshake and load data (memory -> cache)
// Modports: master = cache side, slave = memory_control side.
// ---------------------------------------------------------------------------
interface caches_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  word_t iload;
  logic  iwait;

  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t dload;
  logic  dwait;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iload, iwait, dload, dwait
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    output iload, iwait, dload, dwait
  );

endinterface

// File: rtl/memory_control.sv
// ---------------------------------------------------------------------------
// memory_control
// Arbitrates instruction and data requests from the caches onto a single
// ported RAM. Data has priority, but after DSTREAK consecutive data grants
// with an instruction fetch pending, one instruction grant is forced.
// Ports:
//   CLK, nRST        - clock (rising edge), async active-low reset
//   cif              - caches_if slave modport (requests, waits, load data)
//   ramREN, ramWEN   - RAM read/write enables
//   ramaddr, ramstore- RAM address and write data
//   ramload          - RAM read data
//   ramstate         - RAM status (FREE/BUSY/ACCESS/ERROR)
//   ram_err          - sticky flag, set by an ERROR status during a grant
// ---------------------------------------------------------------------------
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  caches_if.slave   cif,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      ram_err
);

  localparam int CW = $clog2(DSTREAK + 1);
  localparam logic [CW-1:0] STREAK_MAX = CW'(DSTREAK);

  memctl_state_t state_q, state_d;
  logic [CW-1:0] streak_q, streak_d;
  logic          ram_err_q, ram_err_d;
  logic          d_req;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      ram_err_q <= ram_err_d;
    end
  end

  // Load data is passed straight through; it only matters in the cycle
  // the matching wait signal is low.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    ram_err_d  = ram_err_q;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    cif.iwait  = 1'b1;
    cif.dwait  = 1'b1;
    cif.iload  = ramload;
    cif.dload  = ramload;
    d_req      = cif.dREN | cif.dWEN;

    unique case (state_q)
      IDLE: begin
        if (d_req && (streak_q < STREAK_MAX)) begin
          state_d = DGNT;
        end else if (cif.iREN) begin
          state_d = IGNT;
        end else if (d_req) begin
          state_d = DGNT;
        end
        // The streak only counts data grants that made a fetch wait.
        if (!cif.iREN || (state_d == IGNT)) begin
          streak_d = '0;
        end else if ((state_d == DGNT) && (streak_q < STREAK_MAX)) begin
          streak_d = streak_q + 1'b1;
        end
      end

      IGNT: begin
        if (!cif.iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = cif.iaddr;
          if (ramstate == ACCESS) begin
            cif.iwait = 1'b0;
            state_d   = IDLE;
          end else if (ramstate == ERROR) begin
            ram_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      DGNT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr = cif.daddr;
          // A write wins when the cache raises both enables.
          if (cif.dWEN) begin
            ramWEN   = 1'b1;
            ramstore = cif.dstore;
          end else begin
            ramREN   = 1'b1;
          end
          if (ramstate == ACCESS) begin
            cif.dwait = 1'b0;
            state_d   = IDLE;
          end else if (ramstate == ERROR) begin
            ram_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign ram_err = ram_err_q;

endmodule

// File: tb/tb_memory_control.sv
// ---------------------------------------------------------------------------
// tb_memory_control
// Self-checking bench for memory_control. A behavioural model tracks who
// owns the RAM and the data streak, and a compare process checks every DUT
// output against it on each falling clock edge. Directed scenarios pin the
// model with literal expectations, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_memory_control;
  import cpu_types_pkg::*;

  localparam int DSTREAK = 4;

  logic      CLK;
  logic      nRST;
  logic      ramREN, ramWEN, ram_err;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  caches_if cif ();

  memory_control #(.DSTREAK(DSTREAK)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .cif      (cif.slave),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .ram_err  (ram_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge, then returns
  // shortly after the falling edge so the caller can sample outputs.
  task automatic applyStimulus(input logic iren, input word_t ia,
                               input logic dren, input logic dwen,
                               input word_t da, input word_t ds,
                               input ramstate_t rs, input word_t rl);
    @(posedge CLK);
    #1;
    cif.iREN   = iren;
    cif.iaddr  = ia;
    cif.dREN   = dren;
    cif.dWEN   = dwen;
    cif.daddr  = da;
    cif.dstore = ds;
    ramstate   = rs;
    ramload    = rl;
    @(negedge CLK);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model. owner: 0 = nobody (arbitration cycle), 1 = fetch,
  // 2 = data. Expected outputs are derived from the owner and live inputs.
  // -------------------------------------------------------------------------
  int owner = 0, streak = 0;
  bit errFlag = 0;

  always begin
    int   nOwner, nStreak;
    bit   nErr, dReq;
    logic eI, eD, eR, eW;
    word_t eA, eS;

    @(negedge CLK);
    eI = 1'b1; eD = 1'b1; eR = 1'b0; eW = 1'b0; eA = '0; eS = '0;
    nOwner = owner; nStreak = streak; nErr = errFlag;
    dReq = cif.dREN || cif.dWEN;

    if (!nRST) begin
      owner = 0; streak = 0; errFlag = 0;
      nOwner = 0; nStreak = 0; nErr = 0;
    end else if (owner == 0) begin
      bit dataTurn;
      dataTurn = dReq && (!cif.iREN || streak < DSTREAK);
      nOwner = dataTurn ? 2 : (cif.iREN ? 1 : 0);
      if (!cif.iREN)        nStreak = 0;
      else if (nOwner == 1) nStreak = 0;
      else if (nOwner == 2) nStreak = (streak + 1 > DSTREAK) ? DSTREAK : streak + 1;
    end else begin
      bit live;
      live = (owner == 1) ? cif.iREN : dReq;
      if (!live) begin
        nOwner = 0;
      end else begin
        if (owner == 1) begin
          eR = 1'b1; eA = cif.iaddr;
        end else begin
          eA = cif.daddr;
          if (cif.dWEN) begin eW = 1'b1; eS = cif.dstore; end
          else eR = 1'b1;
        end
        if (ramstate == ACCESS) begin
          if (owner == 1) eI = 1'b0; else eD = 1'b0;
          nOwner = 0;
        end else if (ramstate == ERROR) begin
          nErr = 1; nOwner = 0;
        end
      end
    end

    checkOutput("iwait",    32'(cif.iwait), 32'(eI));
    checkOutput("dwait",    32'(cif.dwait), 32'(eD));
    checkOutput("ramREN",   32'(ramREN),    32'(eR));
    checkOutput("ramWEN",   32'(ramWEN),    32'(eW));
    checkOutput("ramaddr",  ramaddr,        eA);
    checkOutput("ramstore", ramstore,       eS);
    checkOutput("ram_err",  32'(ram_err),   32'(errFlag));
    if (!eI) checkOutput("iload", cif.iload, ramload);
    if (!eD) checkOutput("dload", cif.dload, ramload);

    @(posedge CLK);
    if (!nRST) begin
      owner = 0; streak = 0; errFlag = 0;
    end else begin
      owner = nOwner; streak = nStreak; errFlag = nErr;
    end
  end

  // -------------------------------------------------------------------------
  // Directed scenarios followed by randomized traffic.
  // -------------------------------------------------------------------------
  initial begin
    int lowCount;
    logic [9:0] pattern;
    int completions;

    nRST = 1'b0;
    cif.iREN = 0; cif.iaddr = '0; cif.dREN = 0; cif.dWEN = 0;
    cif.daddr = '0; cif.dstore = '0; ramstate = FREE; ramload = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_iwait",  32'(cif.iwait), 32'h1);
    checkOutput("reset_dwait",  32'(cif.dwait), 32'h1);
    checkOutput("reset_ramREN", 32'(ramREN),    32'h0);
    checkOutput("reset_err",    32'(ram_err),   32'h0);
    #1 nRST = 1'b1;

    // Single instruction read, ACCESS two cycles after ramREN.
    lowCount = 0;
    applyStimulus(1, 32'h40, 0, 0, 0, 0, FREE, 32'h0);
    checkOutput("ifetch_bubble", 32'(ramREN), 32'h0);
    if (!cif.iwait) lowCount++;
    applyStimulus(1, 32'h40, 0, 0, 0, 0, BUSY, 32'h0);
    checkOutput("ifetch_ren",  32'(ramREN), 32'h1);
    checkOutput("ifetch_addr", ramaddr, 32'h40);
    if (!cif.iwait) lowCount++;
    applyStimulus(1, 32'h40, 0, 0, 0, 0, BUSY, 32'h0);
    if (!cif.iwait) lowCount++;
    applyStimulus(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C010004);
    checkOutput("ifetch_iload", cif.iload, 32'h8C010004);
    if (!cif.iwait) lowCount++;
    applyStimulus(0, 32'h0, 0, 0, 0, 0, FREE, 32'h0);
    if (!cif.iwait) lowCount++;
    checkOutput("ifetch_low_cycles", 32'(lowCount), 32'd1);

    // Simultaneous fetch and data read: data first.
    applyStimulus(1, 32'h44, 1, 0, 32'h200, 0, FREE, 32'h0);
    applyStimulus(1, 32'h44, 1, 0, 32'h200, 0, ACCESS, 32'h1111);
    checkOutput("prio_daddr", ramaddr, 32'h200);
    checkOutput("prio_dwait", 32'(cif.dwait), 32'h0);
    checkOutput("prio_iwait", 32'(cif.iwait), 32'h1);
    applyStimulus(1, 32'h44, 0, 0, 32'h0, 0, FREE, 32'h0);
    checkOutput("prio_bubble", 32'(ramREN), 32'h0);
    applyStimulus(1, 32'h44, 0, 0, 32'h0, 0, ACCESS, 32'h2222);
    checkOutput("prio_iaddr", ramaddr, 32'h44);
    checkOutput("prio_iwait2", 32'(cif.iwait), 32'h0);
    idleCycle();

    // Starvation guard: both requests held, RAM always ready.
    pattern = '0;
    completions = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 32'h48, 1, 0, 32'h300, 0, ACCESS, 32'(c));
      if (!cif.iwait || !cif.dwait) begin
        completions++;
        pattern = {pattern[8:0], ~cif.iwait};
      end
    end
    checkOutput("starve_count",   32'(completions), 32'd10);
    checkOutput("starve_pattern", 32'(pattern),     32'h021);
    idleCycle();

    // Write wins over read.
    applyStimulus(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, FREE, 32'h0);
    applyStimulus(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, ACCESS, 32'h0);
    checkOutput("wr_wen",   32'(ramWEN), 32'h1);
    checkOutput("wr_ren",   32'(ramREN), 32'h0);
    checkOutput("wr_store", ramstore,    32'hDEADBEEF);
    checkOutput("wr_addr",  ramaddr,     32'h100);
    checkOutput("wr_dwait", 32'(cif.dwait), 32'h0);
    idleCycle();

    // ERROR during a data grant, then withdrawal during BUSY.
    applyStimulus(0, 0, 1, 0, 32'h300, 0, FREE, 32'h0);
    applyStimulus(0, 0, 1, 0, 32'h300, 0, ERROR, 32'h0);
    checkOutput("err_dwait", 32'(cif.dwait), 32'h1);
    applyStimulus(0, 0, 1, 0, 32'h300, 0, FREE, 32'h0);
    checkOutput("err_sticky", 32'(ram_err), 32'h1);
    checkOutput("err_idle",   32'(ramREN),  32'h0);
    applyStimulus(0, 0, 1, 0, 32'h300, 0, BUSY, 32'h0);
    checkOutput("regrant_ren", 32'(ramREN), 32'h1);
    applyStimulus(0, 0, 0, 0, 32'h300, 0, BUSY, 32'h0);
    checkOutput("withdraw_ren",   32'(ramREN),    32'h0);
    checkOutput("withdraw_dwait", 32'(cif.dwait), 32'h1);
    applyStimulus(0, 0, 1, 0, 32'h300, 0, BUSY, 32'h0);
    checkOutput("withdraw_idle", 32'(ramREN), 32'h0);
    idleCycle();
    idleCycle();

    // Reset asserted mid-grant.
    applyStimulus(1, 32'h80, 0, 0, 0, 0, FREE, 32'h0);
    applyStimulus(1, 32'h80, 0, 0, 0, 0, BUSY, 32'h0);
    checkOutput("rst_pre_ren", 32'(ramREN), 32'h1);
    #1 nRST = 1'b0;
    #1;
    checkOutput("rst_ren",   32'(ramREN),    32'h0);
    checkOutput("rst_iwait", 32'(cif.iwait), 32'h1);
    checkOutput("rst_addr",  ramaddr,        32'h0);
    checkOutput("rst_err",   32'(ram_err),   32'h0);
    @(posedge CLK);
    #2 nRST = 1'b1;
    idleCycle();
    idleCycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      int r;
      ramstate_t rs;
      r = int'($urandom_range(99));
      rs = (r < 20) ? FREE : (r < 50) ? BUSY : (r < 90) ? ACCESS : ERROR;
      applyStimulus($urandom_range(99) < 60, $urandom, $urandom_range(99) < 40,
                    $urandom_range(99) < 25, $urandom, $urandom, rs, $urandom);
      if ($urandom_range(199) == 0) begin
        #1 nRST = 1'b0;
        @(posedge CLK);
        #2 nRST = 1'b1;
      end
    end

    @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
